// File: rtl/fp32_exp_align.sv
// Iterative exponent alignment for the fp32 adder: right-shifts the smaller operand's
// significand one bit per cycle until both operands share the larger effective exponent.
module fp32_exp_align (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [31:0] io_a,
  input  logic [31:0] io_b,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [23:0] io_sigA,
  output logic [23:0] io_sigB,
  output logic [7:0]  io_exp,
  output logic        io_signA,
  output logic        io_signB,
  output logic        io_sticky
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      state_q, state_d;
  logic [23:0] sig_a_q, sig_a_d;
  logic [23:0] sig_b_q, sig_b_d;
  logic [7:0]  exp_q, exp_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic        sticky_q, sticky_d;
  logic        shift_a_q, shift_a_d;
  logic [4:0]  cnt_q, cnt_d;

  // Operand decode
  logic [7:0]  raw_exp_a, raw_exp_b;
  logic [7:0]  eff_exp_a, eff_exp_b;
  logic [23:0] in_sig_a, in_sig_b;
  logic        a_smaller;
  logic [7:0]  exp_diff;
  logic [7:0]  exp_max;
  logic        diff_zero;
  logic        diff_large;

  assign raw_exp_a  = io_a[30:23];
  assign raw_exp_b  = io_b[30:23];
  assign eff_exp_a  = (raw_exp_a == 8'd0) ? 8'd1 : raw_exp_a;
  assign eff_exp_b  = (raw_exp_b == 8'd0) ? 8'd1 : raw_exp_b;
  assign in_sig_a   = {raw_exp_a != 8'd0, io_a[22:0]};
  assign in_sig_b   = {raw_exp_b != 8'd0, io_b[22:0]};
  assign a_smaller  = eff_exp_a < eff_exp_b;
  assign exp_diff   = a_smaller ? (eff_exp_b - eff_exp_a) : (eff_exp_a - eff_exp_b);
  assign exp_max    = a_smaller ? eff_exp_b : eff_exp_a;
  assign diff_zero  = exp_diff == 8'd0;
  assign diff_large = exp_diff >= 8'd24;

  // State register and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      sig_a_q   <= '0;
      sig_b_q   <= '0;
      exp_q     <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      sticky_q  <= 1'b0;
      shift_a_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sig_a_q   <= sig_a_d;
      sig_b_q   <= sig_b_d;
      exp_q     <= exp_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      sticky_q  <= sticky_d;
      shift_a_q <= shift_a_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (io_in_valid) begin
          state_d = (diff_zero || diff_large) ? StDone : StShift;
        end
      end
      StShift: begin
        if (cnt_q == 5'd1) state_d = StDone;
      end
      StDone: begin
        if (io_out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: registers move only on the capture edge and on shift edges
  always_comb begin
    sig_a_d   = sig_a_q;
    sig_b_d   = sig_b_q;
    exp_d     = exp_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    sticky_d  = sticky_q;
    shift_a_d = shift_a_q;
    cnt_d     = cnt_q;
    case (state_q)
      StIdle: begin
        if (io_in_valid) begin
          sig_a_d   = in_sig_a;
          sig_b_d   = in_sig_b;
          exp_d     = exp_max;
          sign_a_d  = io_a[31];
          sign_b_d  = io_b[31];
          sticky_d  = 1'b0;
          shift_a_d = a_smaller;
          cnt_d     = exp_diff[4:0];
          // Shift distance covers the whole significand: collapse it in one step
          if (diff_large) begin
            if (a_smaller) begin
              sig_a_d  = '0;
              sticky_d = |in_sig_a;
            end else begin
              sig_b_d  = '0;
              sticky_d = |in_sig_b;
            end
          end
        end
      end
      StShift: begin
        if (shift_a_q) begin
          sig_a_d  = {1'b0, sig_a_q[23:1]};
          sticky_d = sticky_q | sig_a_q[0];
        end else begin
          sig_b_d  = {1'b0, sig_b_q[23:1]};
          sticky_d = sticky_q | sig_b_q[0];
        end
        cnt_d = cnt_q - 5'd1;
      end
      default: ;
    endcase
  end

  // Output logic
  always_comb begin
    io_in_ready  = (state_q == StIdle);
    io_out_valid = (state_q == StDone);
  end

  assign io_sigA   = sig_a_q;
  assign io_sigB   = sig_b_q;
  assign io_exp    = exp_q;
  assign io_signA  = sign_a_q;
  assign io_signB  = sign_b_q;
  assign io_sticky = sticky_q;

  // The shift counter is never zero while shifting; zero would wrap to 31 extra shifts
  shift_cnt_nonzero: assert property (@(posedge clock) disable iff (reset)
    (state_q == StShift) |-> (cnt_q != 5'd0));

  valid_held_under_backpressure: assert property (@(posedge clock) disable iff (reset)
    (io_out_valid && !io_out_ready) |=> io_out_valid);

endmodule

// File: tb/tb_fp32_exp_align.sv
// Scoreboard bench for fp32_exp_align: stimulus pushes model results, a negedge monitor
// pops and compares them, and also checks latency, hold stability and ready behaviour.
module tb_fp32_exp_align;

  logic        clock;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [31:0] io_a;
  logic [31:0] io_b;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [23:0] io_sigA;
  logic [23:0] io_sigB;
  logic [7:0]  io_exp;
  logic        io_signA;
  logic        io_signB;
  logic        io_sticky;

  fp32_exp_align dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_a         (io_a),
    .io_b         (io_b),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_sigA      (io_sigA),
    .io_sigB      (io_sigB),
    .io_exp       (io_exp),
    .io_signA     (io_signA),
    .io_signB     (io_signB),
    .io_sticky    (io_sticky)
  );

  typedef struct {
    logic [23:0] sa;
    logic [23:0] sb;
    logic [7:0]  e;
    logic        pa;
    logic        pb;
    logic        st;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rdy_mode = 1;  // 0: hold low, 1: always high, 2: random

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the alignment rules
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   r;
    int     ea, eb, d;
    longint siga, sigb, sh;
    logic   st;
    ea   = (a[30:23] == 0) ? 1 : int'(a[30:23]);
    eb   = (b[30:23] == 0) ? 1 : int'(b[30:23]);
    siga = ((a[30:23] != 0) ? 64'h800000 : 64'h0) + longint'(a[22:0]);
    sigb = ((b[30:23] != 0) ? 64'h800000 : 64'h0) + longint'(b[22:0]);
    st   = 1'b0;
    if (ea < eb) begin
      d    = eb - ea;
      sh   = siga >> d;
      st   = ((sh << d) != siga);
      siga = sh;
    end else begin
      d    = ea - eb;
      sh   = sigb >> d;
      st   = ((sh << d) != sigb);
      sigb = sh;
    end
    r.sa  = siga[23:0];
    r.sb  = sigb[23:0];
    r.e   = 8'((ea > eb) ? ea : eb);
    r.pa  = a[31];
    r.pb  = b[31];
    r.st  = st;
    r.lat = (d == 0 || d >= 24) ? 1 : d + 1;
    r.acc = 0;
    return r;
  endfunction

  // Ready driver: the only writer of io_out_ready
  initial begin
    io_out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        0:       io_out_ready = 1'b0;
        1:       io_out_ready = 1'b1;
        default: io_out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor
  initial begin
    logic        prev_valid, prev_fire;
    logic [23:0] h_sa, h_sb;
    logic [7:0]  h_e;
    logic [2:0]  h_flags;
    exp_t        e;
    prev_valid = 1'b0;
    prev_fire  = 1'b0;
    h_sa = '0; h_sb = '0; h_e = '0; h_flags = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_valid = 1'b0;
        prev_fire  = 1'b0;
      end else begin
        if (prev_fire) chk("in_ready_after_fire", 32'(io_in_ready), 32'd1);
        if (io_out_valid) begin
          chk("in_ready_low_while_valid", 32'(io_in_ready), 32'd0);
          if (!prev_valid || prev_fire) begin
            if (sb_q.size() == 0) begin
              chk("unexpected_result", 32'd1, 32'd0);
            end else begin
              e = sb_q.pop_front();
              chk("sigA", 32'(io_sigA), 32'(e.sa));
              chk("sigB", 32'(io_sigB), 32'(e.sb));
              chk("exp", 32'(io_exp), 32'(e.e));
              chk("signA", 32'(io_signA), 32'(e.pa));
              chk("signB", 32'(io_signB), 32'(e.pb));
              chk("sticky", 32'(io_sticky), 32'(e.st));
              chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
          end else begin
            chk("hold_stable", {io_sigA, io_exp}, {h_sa, h_e});
            chk("hold_stable_b", {5'd0, io_sigB, io_signA, io_signB, io_sticky},
                {5'd0, h_sb, h_flags});
          end
          h_sa = io_sigA; h_sb = io_sigB; h_e = io_exp;
          h_flags = {io_signA, io_signB, io_sticky};
        end else begin
          if (prev_valid && !prev_fire) chk("valid_dropped", 32'd0, 32'd1);
          if (sb_q.size() != 0 && (cyc - sb_q[0].acc) > 30) begin
            chk("latency_timeout", 32'(cyc - sb_q[0].acc), 32'(sb_q[0].lat));
            void'(sb_q.pop_front());
          end
        end
        prev_valid = io_out_valid;
        prev_fire  = io_out_valid & io_out_ready;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    bit   done;
    done = 1'b0;
    @(posedge clock);
    #1;
    io_a = a;
    io_b = b;
    io_in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      if (io_in_ready) begin
        if (push) begin
          e = model(a, b);
          e.acc = cyc;
          sb_q.push_back(e);
        end
        done = 1'b1;
      end
      @(posedge clock);
      #1;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    io_in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clock);
      if (sb_q.size() == 0 && !io_out_valid) ok = 1'b1;
    end
    if (!ok) chk("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] rand_operand(input int ex);
    logic [22:0] fr;
    fr = ($urandom_range(0, 5) == 0) ? 23'd0 : 23'($urandom());
    return {1'($urandom()), 8'(ex), fr};
  endfunction

  initial begin
    int ea, eb;
    bit got;
    reset = 1'b1;
    io_in_valid = 1'b0;
    io_a = '0;
    io_b = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", 32'(io_in_ready), 32'd1);
    chk("rst_out_valid", 32'(io_out_valid), 32'd0);
    chk("rst_outputs", {io_sigA, io_exp}, 32'd0);
    chk("rst_outputs_b", {5'd0, io_sigB, io_signA, io_signB, io_sticky}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Directed corner cases
    issue(32'h3F800000, 32'h3F800000, 1'b1);
    issue(32'h40000000, 32'h3F800000, 1'b1);
    issue(32'h3F800000, 32'h4B000000, 1'b1);
    issue(32'h3FC00000, 32'h4B800000, 1'b1);
    issue(32'h00000001, 32'h00800000, 1'b1);
    issue(32'hC0400000, 32'h3E000001, 1'b1);
    wait_drain();

    // Backpressure: hold ready low five cycles past valid
    rdy_mode = 0;
    issue(32'h40000000, 32'h3F800000, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      got = io_out_valid;
    end
    chk("bp_valid_seen", 32'(got), 32'd1);
    repeat (5) @(negedge clock);
    rdy_mode = 1;
    wait_drain();

    // Reset in the middle of a long shift
    issue(32'h3F800000, 32'h4B000000, 1'b0);
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("abort_out_valid", 32'(io_out_valid), 32'd0);
    chk("abort_in_ready", 32'(io_in_ready), 32'd1);
    issue(32'h3F800000, 32'h3F800000, 1'b1);
    wait_drain();

    // Randomised pairs with random backpressure
    rdy_mode = 2;
    for (int n = 0; n < 150; n++) begin
      ea = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        eb = int'($urandom_range(0, 255));
      end else begin
        eb = ea + int'($urandom_range(0, 60)) - 30;
        if (eb < 0) eb = 0;
        if (eb > 255) eb = 255;
      end
      issue(rand_operand(ea), rand_operand(eb), 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clock);
    end
    rdy_mode = 1;
    wait_drain();
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp32_exp_align.md
# fp32_exp_align

Iterative exponent-alignment stage for the fp32 adder datapath, directly upstream of the mantissa adder. Accepts two fp32 operands over a valid/ready handshake and compares their exponents. It right-shifts the smaller operand's significand one bit per cycle until both share the larger exponent, then presents aligned 24-bit significands, the common exponent and a sticky bit to the mantissa-add stage.

## Interface
- No parameters; fixed fp32 format (1 sign, 8 exponent, 23 fraction bits).
- clock  input  1  sole clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- io_in_valid  input  1  operand pair valid
- io_in_ready  output  1  block can accept an operand pair
- io_a  input  32  fp32 operand A
- io_b  input  32  fp32 operand B
- io_out_valid  output  1  aligned result valid
- io_out_ready  input  1  downstream accepts result
- io_sigA  output  24  aligned significand A, explicit leading bit at [23]
- io_sigB  output  24  aligned significand B, explicit leading bit at [23]
- io_exp  output  8  common (larger effective) exponent
- io_signA, io_signB  output  1 each  operand signs, passed through unchanged
- io_sticky  output  1  OR of all bits shifted out of the smaller significand

## Operation
- Significand of each operand: hidden bit = (exponent != 0), concatenated with the fraction, giving 24 bits.
- Effective exponent: the raw exponent, except 0 is treated as 1 (denormals).
- Exponent difference: d = |effExpA - effExpB|. The operand with the smaller effective exponent is the one shifted. Operand order is preserved on the outputs; A and B are never swapped.
- io_exp = max(effExpA, effExpB).
- State machine: IDLE, SHIFT, DONE.
  - IDLE: io_in_ready=1. On io_in_valid, capture both operands, d and the signs, and clear sticky.
    - d=0 -> DONE.
    - 1<=d<=23 -> SHIFT with counter=d.
    - d>=24 -> DONE, with the smaller significand forced to 0 and sticky = (smaller significand != 0).
  - SHIFT: each cycle, shift the smaller significand right by 1, OR the bit shifted out into sticky, and decrement the counter. When the counter reaches 0 (i.e. after d shifts) -> DONE.
  - DONE: io_out_valid=1 and all outputs held stable. On io_out_ready -> IDLE.
- io_in_ready is 0 outside IDLE, so a new operand pair is never accepted in the same cycle a result is consumed.
- NaN/Inf are not special-cased. Exponent 0xFF is aligned like any other value; flagging is done downstream.

## Timing
- Reset: state=IDLE, io_in_ready=1, io_out_valid=0, io_sigA=io_sigB=0, io_exp=0, io_sticky=0, io_signA=io_signB=0.
- Latency is counted from the accept edge (io_in_valid & io_in_ready) to the first cycle with io_out_valid=1:
  - 1 cycle for d=0 or d>=24;
  - d+1 cycles for 1<=d<=23.
- Maximum latency is 24 cycles, at d=23.
- After the output fire edge, io_in_ready=1 in the next cycle. Minimum initiation interval is 2 cycles.
- Backpressure: io_out_valid stays 1 and all outputs stay bit-stable while io_out_ready=0, for an unbounded time.
- Reset asserted in any state returns the block to IDLE on the next edge and discards any in-flight operation. No result is emitted for the aborted pair.
- Output registers update only on the capture edge and on SHIFT edges; their values are undefined-but-stable while io_out_valid=0.

## Test plan
- Equal exponents: a=0x3F800000, b=0x3F800000 -> after 1 cycle: sigA=sigB=0x800000, exp=0x7F, sticky=0.
- One-bit shift: a=0x40000000, b=0x3F800000 -> after 2 cycles: sigA=0x800000, sigB=0x400000, exp=0x80, sticky=0.
- Maximum iterative shift: a=0x3F800000, b=0x4B000000 (d=23) -> after 24 cycles: sigA=0x000001, sigB=0x800000, exp=0x96, sticky=0. Also a=0x3FC00000 with b=0x4B800000 (d=24) -> after 1 cycle: sigA=0, exp=0x97, sticky=1.
- Denormal versus smallest normal: a=0x00000001, b=0x00800000 -> d=0, after 1 cycle: sigA=0x000001, sigB=0x800000, exp=0x01.
- Backpressure: hold io_out_ready=0 for 5 cycles after io_out_valid rises -> outputs constant, io_in_ready=0; release -> io_in_ready=1 on the next cycle.
- Reset mid-SHIFT: start the d=23 case, assert reset at cycle 10 -> next cycle io_out_valid=0, io_in_ready=1. A new d=0 pair then completes in 1 cycle with correct values.
